// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//   Reset sequencer.  Merges the master reset, a software reset request and an
//   asynchronous external reset request into NUM_CH active-low domain resets.
//   All domains are held low for MIN_ASSERT cycles after the last request.
//   They are then released one at a time, REL_GAP cycles apart, starting at
//   channel 0.  A sticky cause register tells software what caused the last
//   reset(s).
//
//   Ports
//     clk            clock
//     rst            master reset, synchronous, active-high
//     sw_rst_req     software reset request (clk domain, level)
//     ext_rst_req_n  external reset request (asynchronous, active-low)
//     cause_clr      one-cycle pulse that clears rst_cause
//     rst_n_out      active-low domain resets, ch0 released first
//     all_released   high while every channel is released (RUN)
//     state          0=HOLD 1=RELEASE 2=RUN
//     rst_cause      sticky cause: [0]=master [1]=sw [2]=ext
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   HOLD     | every output low, counting out the minimum assert time
//   RELEASE  | channels releasing one at a time, REL_GAP cycles apart
//   RUN      | all channels released, outputs static
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_ASSERT  = 16,
    parameter int REL_GAP     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst_req,
    input  logic              ext_rst_req_n,
    input  logic              cause_clr,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              all_released,
    output logic [1:0]        state,
    output logic [2:0]        rst_cause
);

    localparam int CNT_MAX = (MIN_ASSERT > REL_GAP) ? MIN_ASSERT : REL_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int CH_W    = $clog2(NUM_CH) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(REL_GAP - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
    logic [NUM_CH-1:0]   rst_n_q, rst_n_d;
    logic                all_rel_q, all_rel_d;
    logic [2:0]          cause_q, cause_d;
    logic [SYNC_STAGES-1:0] ext_sync_q;
    logic                ext_s;
    logic                req;

    // Only asynchronous crossing in the block; reset value means "no request".
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_sync_q <= '1;
        end else begin
            ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], ext_rst_req_n};
        end
    end

    assign ext_s = ext_sync_q[SYNC_STAGES-1];
    assign req   = sw_rst_req | ~ext_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            ch_idx_q  <= '0;
            rst_n_q   <= '0;
            all_rel_q <= 1'b0;
            cause_q   <= 3'b001;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_idx_q  <= ch_idx_d;
            rst_n_q   <= rst_n_d;
            all_rel_q <= all_rel_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_idx_d  = ch_idx_q;
        rst_n_d   = rst_n_q;
        all_rel_d = all_rel_q;
        cause_d   = cause_clr ? 3'b000 : cause_q;

        if (req) begin
            // A new request beats a same-cycle clear: only the new bits survive.
            cause_d   = cause_d | {~ext_s, sw_rst_req, 1'b0};
            rst_n_d   = '0;
            all_rel_d = 1'b0;
            state_d   = ST_HOLD;
            cnt_d     = '0;
            ch_idx_d  = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_n_d[0] = 1'b1;
                        cnt_d      = '0;
                        ch_idx_d   = CH_W'(1);
                        if (NUM_CH == 1) begin
                            all_rel_d = 1'b1;
                            state_d   = ST_RUN;
                        end else begin
                            state_d   = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (CH_W'(i) == ch_idx_q) begin
                                rst_n_d[i] = 1'b1;
                            end
                        end
                        cnt_d    = '0;
                        ch_idx_d = ch_idx_q + 1'b1;
                        if (ch_idx_q == CH_LAST) begin
                            all_rel_d = 1'b1;
                            state_d   = ST_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    assign rst_n_out    = rst_n_q;
    assign all_released = all_rel_q;
    assign state        = state_q;
    assign rst_cause    = cause_q;

endmodule
